sram_like_resp: RTL
===================

Name: sram_like_resp

Overview:
- SRAM-like slave (responder) for the data-side request channel issued by the pipeline's EX stage.
- Accepts requests on req/addr_ok, performs a word-array read or byte-strobed write, and returns in-order responses on data_ok/rdata after a fixed delay.
- Used as the data-RAM model behind the core in simulation and as the on-chip scratch RAM in small configurations.
- Supports multiple outstanding requests, so the core's MEM stage can overlap address and data phases.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2^ADDR_W 32-bit words.
- RESP_DELAY, 2, cycles from accept to earliest data_ok; legal range 1..15.
- MAX_OUT, 2, maximum outstanding (accepted, not yet responded) requests; legal range 1..4.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1=write, 0=read.
- data_sram_size  in  2  0=byte, 1=half, 2=word; informational only, strobes govern writes.
- data_sram_addr  in  32  byte address.
- data_sram_wstrb  in  4  byte write enables; ignored for reads.
- data_sram_wdata  in  32  write data, byte lanes already replicated by the requester.
- data_sram_addr_ok  out  1  request accepted this cycle when req is also 1.
- data_sram_data_ok  out  1  one response completes this cycle.
- data_sram_rdata  out  32  read data; valid when data_ok is 1 and the response belongs to a read.

Behaviour:
- Reset (resetn=0, asynchronous):
  - addr_ok=0, data_ok=0, rdata=0.
  - Outstanding count=0; queue pointers=0.
  - Memory array is not reset.
  - Reset mid-operation drops all pending responses; no data_ok is issued for them after reset release.
- addr_ok = (count < MAX_OUT).
  - Depends only on registered state, never on req, so there is no combinational req->addr_ok path.
- Accept (handshake) = req & addr_ok.
  - Word index = addr[ADDR_W+1:2]; upper address bits ignored, so addresses wrap modulo the array size.
  - Write: for each i, if wstrb[i] then mem[idx] byte i <= wdata byte i. Takes effect at the accept edge.
  - Read: mem[idx] is sampled at the accept edge and stored in the queue entry, so a read sees all writes accepted earlier. rdata is always the full word; the requester extracts bytes.
  - Entry pushed: {is_wr, data, timer=RESP_DELAY-1}.
- Queue: circular FIFO of MAX_OUT entries with head/tail pointers.
  - All entry timers decrement each cycle (saturate at 0), so entries age concurrently.
  - Head completes when its timer==0: registered data_ok=1 in the following cycle, rdata=head data for a read, rdata=0 for a write, head popped.
  - Net latency: request accepted at edge T gives data_ok high in cycle T+RESP_DELAY.
  - Back-to-back accepts give back-to-back data_ok cycles.
  - At most one data_ok per cycle; responses strictly in accept order.
- Full:
  - count==MAX_OUT gives addr_ok=0.
  - A pop in the same cycle does NOT reopen addr_ok until the next cycle (no bypass).
- Simultaneous push and pop: count unchanged; both pointers advance.
- data_ok low: rdata holds its last value. No backpressure on the response side; the requester must always accept data_ok.
- req with addr_ok=0: nothing recorded; the requester holds the request.

Optional Feature:
- Macro SRAM_RESP_RAND_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances every cycle.
  - addr_ok is additionally gated by ~lfsr[0], stalling roughly half the accept opportunities to stress requester hold and cancel logic.
  - Data-phase timing is unchanged.
- Undefined: no LFSR logic; addr_ok exactly as above.

Test Plan:
- Write then read, RESP_DELAY=2: wr addr 0x10, wstrb 4'b1111, wdata 0x12345678 accepted at T0; rd 0x10 accepted at T1 -> data_ok at T2 with rdata 0; data_ok at T3 with rdata 0x12345678.
- Byte strobes: word 0x20 = 0xFFFFFFFF; write wstrb 4'b0100, wdata 0xABABABAB; read 0x20 -> rdata 0xFFABFFFF.
- Full, MAX_OUT=2: req held high with reads 0x0, 0x4, 0x8 -> addr_ok 1,1,0; third accepted one cycle after the first data_ok; exactly three data_ok pulses, in order.
- Wrap, ADDR_W=10: write 0x1000_0004 = 0xDEADBEEF; read 0x0000_0004 -> 0xDEADBEEF.
- Reset mid-flight: two reads accepted, resetn pulsed low before any data_ok -> addr_ok, data_ok, rdata go 0 immediately; no data_ok for 20 cycles after release.
- SRAM_RESP_RAND_STALL_EN defined: 100 random requests held until accepted -> all complete in order with correct data, and at least one addr_ok=0 cycle is observed while count<MAX_OUT.

Source files
------------

// File: rtl/sram_like_resp.sv
// SRAM-like data-side responder: word array with byte-strobed writes and in-order delayed responses.
// Optional `define SRAM_RESP_RAND_STALL_EN gates addr_ok with an LFSR to randomly stall requests.
module sram_like_resp #(
   parameter int unsigned ADDR_W     = 10,
   parameter int unsigned RESP_DELAY = 2,
   parameter int unsigned MAX_OUT    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int unsigned PTR_W      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned DEPTH      = 1 << ADDR_W;
   localparam logic [3:0]  TIMER_INIT = 4'(RESP_DELAY - 1);

   logic [31:0]       mem [DEPTH];
   logic              ent_wr    [MAX_OUT];
   logic [31:0]       ent_data  [MAX_OUT];
   logic [3:0]        ent_timer [MAX_OUT];

   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [2:0]        count_q, count_d;
   logic              data_ok_q, data_ok_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              run_q;
   logic              slot_free, accept, pop;
   logic [ADDR_W-1:0] idx;

   logic unused_bits;
   assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
   endfunction

   assign idx = data_sram_addr[ADDR_W+1:2];

`ifdef SRAM_RESP_RAND_STALL_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   assign slot_free = run_q & (count_q < 3'(MAX_OUT)) & ~lfsr_q[0];
`else
   assign slot_free = run_q & (count_q < 3'(MAX_OUT));
`endif

   // Registered state only: no combinational req -> addr_ok path.
   assign data_sram_addr_ok = slot_free;
   assign data_sram_data_ok = data_ok_q;
   assign data_sram_rdata   = rdata_q;

   assign accept = data_sram_req & slot_free;
   assign pop    = (count_q != 3'd0) && (ent_timer[head_q] == 4'd0);

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      data_ok_d = 1'b0;
      rdata_d   = rdata_q;
      if (accept) begin
         tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
         head_d    = ptr_inc(head_q);
         data_ok_d = 1'b1;
         rdata_d   = ent_wr[head_q] ? 32'd0 : ent_data[head_q];
      end
      unique case ({accept, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= 3'd0;
         data_ok_q <= 1'b0;
         rdata_q   <= 32'd0;
         run_q     <= 1'b0;
         for (int i = 0; i < int'(MAX_OUT); i++) begin
            ent_timer[i] <= 4'd0;
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         data_ok_q <= data_ok_d;
         rdata_q   <= rdata_d;
         run_q     <= 1'b1;
         // Every entry ages each cycle; a freshly pushed entry starts its own countdown.
         for (int i = 0; i < int'(MAX_OUT); i++) begin
            if (accept && (tail_q == PTR_W'(i))) begin
               ent_timer[i] <= TIMER_INIT;
            end else if (ent_timer[i] != 4'd0) begin
               ent_timer[i] <= ent_timer[i] - 4'd1;
            end
         end
      end
   end

   // Array and entry payloads are deliberately not reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
               if (data_sram_wstrb[b]) begin
                  mem[idx][b*8 +: 8] <= data_sram_wdata[b*8 +: 8];
               end
            end
         end
         ent_wr[tail_q]   <= data_sram_wr;
         ent_data[tail_q] <= mem[idx];
      end
   end

endmodule
